// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: one-stage SimpleRISC decoder with a registered control
// word, valid/ready handshakes on both sides and a load-use interlock that
// inserts a single bubble when the incoming instruction reads the
// destination of a load that is still held in the output register.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. On the upstream side, in_ready does not depend on in_valid except
// through the hazard term. Downstream, once out_valid is 1 the control word
// stays stable until out_ready is seen high.
module ctrl_decode_pipe #(
  parameter int REG_W     = 4,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic             imm_bit,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_ret,
  output logic             is_st,
  output logic             is_wb,
  output logic             is_imm,
  output logic             is_beq,
  output logic             is_bgt,
  output logic             is_ubranch,
  output logic             is_ld,
  output logic             is_call,
  output logic [3:0]       alu_op,
  output logic [REG_W-1:0] out_rd,
  output logic             illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  typedef struct packed {
    logic       illegal;
    logic       is_ret;
    logic       is_st;
    logic       is_wb;
    logic       is_imm;
    logic       is_beq;
    logic       is_bgt;
    logic       is_ubranch;
    logic       is_ld;
    logic       is_call;
    logic [3:0] alu_op;
  } ctrl_t;

  ctrl_t            dec;
  ctrl_t            held;
  logic [REG_W-1:0] held_rd;
  logic             use_rs1;
  logic             use_rs2;
  logic             use_rd;
  logic             src_hit;
  logic             hazard;
  logic             accept;

  // Decode the offered instruction and work out which fields it reads.
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    if (opcode <= OP_ASR) begin
      dec.alu_op = opcode[3:0];
      dec.is_imm = imm_bit;
      dec.is_wb  = (opcode != OP_CMP);
      use_rs1    = (opcode != OP_NOT) && (opcode != OP_MOV);
      use_rs2    = (opcode != OP_NOT) && (opcode != OP_MOV) && !imm_bit;
    end else begin
      case (opcode)
        OP_NOP:  dec = '0;
        OP_LD: begin
          dec.is_ld  = 1'b1;
          dec.is_wb  = 1'b1;
          dec.is_imm = imm_bit;
          use_rs1    = 1'b1;
        end
        OP_ST: begin
          dec.is_st  = 1'b1;
          dec.is_imm = imm_bit;
          use_rs1    = 1'b1;
          use_rd     = 1'b1;
        end
        OP_BEQ:  dec.is_beq = 1'b1;
        OP_BGT:  dec.is_bgt = 1'b1;
        OP_B:    dec.is_ubranch = 1'b1;
        OP_CALL: begin
          dec.is_call    = 1'b1;
          dec.is_ubranch = 1'b1;
          dec.is_wb      = 1'b1;
        end
        OP_RET: begin
          dec.is_ret     = 1'b1;
          dec.is_ubranch = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // Load-use interlock and upstream ready.
  always_comb begin
    src_hit  = (use_rs1 && (rs1 == held_rd)) ||
               (use_rs2 && (rs2 == held_rd)) ||
               (use_rd  && (rd  == held_rd));
    hazard   = (HAZARD_EN != 0) && in_valid && out_valid && held.is_ld && src_hit;
    in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  // Output register, valid bit and saturating bubble counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      held       <= '0;
      held_rd    <= '0;
      bubble_cnt <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        held      <= dec;
        held_rd   <= rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (!flush && hazard && out_ready && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign illegal    = held.illegal;
  assign is_ret     = held.is_ret;
  assign is_st      = held.is_st;
  assign is_wb      = held.is_wb;
  assign is_imm     = held.is_imm;
  assign is_beq     = held.is_beq;
  assign is_bgt     = held.is_bgt;
  assign is_ubranch = held.is_ubranch;
  assign is_ld      = held.is_ld;
  assign is_call    = held.is_call;
  assign alu_op     = held.alu_op;
  assign out_rd     = held_rd;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: two instances (interlock on / off) share the
// same stimulus; a behavioural model predicts ready, valid, control word and
// bubble count every cycle.
module tb_ctrl_decode_pipe;

  localparam int RW = 4;
  localparam int CW = 3;
  localparam int WW = 14 + RW;
  // Bit positions in the packed observed/expected control word.
  localparam int B_CALL = RW + 4;
  localparam int B_LD   = RW + 5;
  localparam int B_UBR  = RW + 6;
  localparam int B_BGT  = RW + 7;
  localparam int B_BEQ  = RW + 8;
  localparam int B_IMM  = RW + 9;
  localparam int B_WB   = RW + 10;
  localparam int B_ST   = RW + 11;
  localparam int B_RET  = RW + 12;
  localparam int B_ILL  = RW + 13;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready, imm_bit;
  logic [4:0]    opcode;
  logic [RW-1:0] rd, rs1, rs2;

  logic [1:0]          rdy;
  logic [1:0]          ov;
  logic [1:0][WW-1:0]  word;
  logic [1:0][CW-1:0]  bcnt;

  // model state per instance
  logic          m_v [2];
  logic [WW-1:0] m_w [2];
  logic [CW-1:0] m_c [2];
  logic          m_z [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ctrl_decode_pipe #(.REG_W(RW), .HAZARD_EN(g == 0 ? 1 : 0), .CNT_W(CW)) u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy[g]),
      .opcode(opcode), .imm_bit(imm_bit), .rd(rd), .rs1(rs1), .rs2(rs2),
      .out_valid(ov[g]), .out_ready(out_ready),
      .is_ret(word[g][B_RET]), .is_st(word[g][B_ST]), .is_wb(word[g][B_WB]),
      .is_imm(word[g][B_IMM]), .is_beq(word[g][B_BEQ]), .is_bgt(word[g][B_BGT]),
      .is_ubranch(word[g][B_UBR]), .is_ld(word[g][B_LD]), .is_call(word[g][B_CALL]),
      .alu_op(word[g][RW+3:RW]), .out_rd(word[g][RW-1:0]),
      .illegal(word[g][B_ILL]), .bubble_cnt(bcnt[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control word straight from the instruction-set table.
  function automatic logic [WW-1:0] ref_decode(input int op, input logic im, input logic [RW-1:0] d);
    logic [WW-1:0] w;
    logic alu_grp;
    w = '0;
    alu_grp = (op <= 12);
    w[RW-1:0] = d;
    if (op >= 21) begin
      w[B_ILL] = 1'b1;
      return w;
    end
    if (alu_grp) w[RW+3:RW] = 4'(op);
    w[B_WB]   = (alu_grp && op != 5) || op == 14 || op == 19;
    w[B_IMM]  = (alu_grp || op == 14 || op == 15) ? im : 1'b0;
    w[B_UBR]  = (op == 18 || op == 19 || op == 20);
    w[B_BEQ]  = (op == 16);
    w[B_BGT]  = (op == 17);
    w[B_LD]   = (op == 14);
    w[B_ST]   = (op == 15);
    w[B_CALL] = (op == 19);
    w[B_RET]  = (op == 20);
    return w;
  endfunction

  function automatic logic ref_hazard(input int k, input logic iv, input int op, input logic im,
                                      input logic [RW-1:0] d, s1, s2);
    logic [RW-1:0] ld_rd;
    logic alu_rd_srcs, r1, r2, rds;
    if (k == 1 || !iv || !m_v[k] || !m_w[k][B_LD]) return 1'b0;
    ld_rd = m_w[k][RW-1:0];
    alu_rd_srcs = (op <= 12) && op != 8 && op != 9;
    r1  = alu_rd_srcs || op == 14 || op == 15;
    r2  = alu_rd_srcs && !im;
    rds = (op == 15);
    return (r1 && s1 == ld_rd) || (r2 && s2 == ld_rd) || (rds && d == ld_rd);
  endfunction

  // One clock: drive at negedge, check settled values, advance model at posedge.
  task automatic cycle(input logic r, f, iv, ordy, input logic [4:0] op, input logic im,
                       input logic [RW-1:0] d, s1, s2);
    logic hz [2];
    logic er [2];
    @(negedge clk);
    reset = r; flush = f; in_valid = iv; out_ready = ordy;
    opcode = op; imm_bit = im; rd = d; rs1 = s1; rs2 = s2;
    #1;
    for (int k = 0; k < 2; k++) begin
      hz[k] = ref_hazard(k, iv, int'(op), im, d, s1, s2);
      er[k] = !r && !f && !hz[k] && (!m_v[k] || ordy);
      check($sformatf("in_ready[%0d]", k), 32'(rdy[k]), 32'(er[k]));
      check($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(m_v[k]));
      if (m_v[k] || m_z[k]) check($sformatf("word[%0d]", k), 32'(word[k]), 32'(m_w[k]));
      check($sformatf("bubble_cnt[%0d]", k), 32'(bcnt[k]), 32'(m_c[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_v[k] = 1'b0; m_w[k] = '0; m_c[k] = '0; m_z[k] = 1'b1;
      end else begin
        if (f) m_v[k] = 1'b0;
        else if (iv && er[k]) begin
          m_v[k] = 1'b1; m_w[k] = ref_decode(int'(op), im, d); m_z[k] = 1'b0;
        end else if (ordy) m_v[k] = 1'b0;
        if (!f && hz[k] && ordy && m_c[k] != '1) m_c[k] = m_c[k] + 1'b1;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, ordy, 5'd13, 1'b0, '0, '0, '0);
  endtask

  task automatic instr(input logic ordy, input logic [4:0] op, input logic im,
                       input logic [RW-1:0] d, s1, s2);
    cycle(1'b0, 1'b0, 1'b1, ordy, op, im, d, s1, s2);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 1'b0; m_w[k] = '0; m_c[k] = '0; m_z[k] = 1'b0;
    end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; imm_bit = 1'b0; rd = '0; rs1 = '0; rs2 = '0;

    // reset, then add r1,r2,r3
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 4'd1, 4'd2, 4'd3);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, '0, '0, '0);
    instr(1'b1, 5'd0, 1'b0, 4'd1, 4'd2, 4'd3);
    idle(1'b1);
    idle(1'b1);

    // ld r5 then dependent add r6,r5,r2
    instr(1'b1, 5'd14, 1'b0, 4'd5, 4'd0, 4'd0);
    instr(1'b1, 5'd0,  1'b0, 4'd6, 4'd5, 4'd2);
    instr(1'b1, 5'd0,  1'b0, 4'd6, 4'd5, 4'd2);
    idle(1'b1);
    #1;
    check("bubble_after_ld_use", 32'(bcnt[0]), 32'd1);
    check("no_bubble_hz_off", 32'(bcnt[1]), 32'd0);

    // ld r5 then add r6,r1,#5: immediate field does not create a hazard
    instr(1'b1, 5'd14, 1'b0, 4'd5, 4'd0, 4'd0);
    instr(1'b1, 5'd0,  1'b1, 4'd6, 4'd1, 4'd5);
    idle(1'b1);
    #1;
    check("no_bubble_imm", 32'(bcnt[0]), 32'd1);

    // store reading the loaded register through its rd field
    instr(1'b1, 5'd14, 1'b0, 4'd9, 4'd0, 4'd0);
    instr(1'b1, 5'd15, 1'b1, 4'd9, 4'd1, 4'd0);
    instr(1'b1, 5'd15, 1'b1, 4'd9, 4'd1, 4'd0);
    idle(1'b1);

    // mov held under back-pressure for three cycles
    instr(1'b0, 5'd9, 1'b1, 4'd7, 4'd0, 4'd3);
    for (int i = 0; i < 3; i++) instr(1'b0, 5'd0, 1'b0, 4'd2, 4'd1, 4'd1);
    instr(1'b1, 5'd0, 1'b0, 4'd2, 4'd1, 4'd1);
    idle(1'b1);

    // illegal opcode, call, ret, branches
    instr(1'b1, 5'd24, 1'b1, 4'd4, 4'd4, 4'd4);
    instr(1'b1, 5'd19, 1'b0, 4'd15, 4'd0, 4'd0);
    instr(1'b1, 5'd20, 1'b0, 4'd0, 4'd0, 4'd0);
    instr(1'b1, 5'd17, 1'b0, 4'd0, 4'd0, 4'd0);
    idle(1'b1);

    // flush while a beq is offered
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 5'd16, 1'b0, 4'd0, 4'd0, 4'd0);
    idle(1'b1);

    // reset during a stall
    instr(1'b0, 5'd14, 1'b0, 4'd3, 4'd0, 4'd0);
    instr(1'b0, 5'd0,  1'b0, 4'd4, 4'd3, 4'd3);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 4'd4, 4'd3, 4'd3);
    idle(1'b1);
    #1;
    check("reset_stall_word", 32'(word[0]), 32'd0);
    check("reset_stall_valid", 32'(ov[0]), 32'd0);

    // saturate the bubble counter
    for (int i = 0; i < 9; i++) begin
      instr(1'b1, 5'd14, 1'b0, 4'd2, 4'd0, 4'd0);
      instr(1'b1, 5'd1,  1'b0, 4'd1, 4'd2, 4'd2);
      instr(1'b1, 5'd1,  1'b0, 4'd1, 4'd2, 4'd2);
    end
    idle(1'b1);
    #1;
    check("bubble_saturate", 32'(bcnt[0]), 32'd7);

    // randomized traffic
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 3) == 0) ? 5'd14 : 5'($urandom_range(0, 31));
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
            op, 1'($urandom_range(0, 1)),
            RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)));
    end
    idle(1'b1);
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
